// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the small ARM-like core: program-counter width,
// one-hot phase encodings of the sequencer, instruction opcode constants and
// an opcode classifier shared by the sequencer and the ALU.
// No ports (package).
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int PC_W = 8;
    typedef logic [PC_W-1:0] pc_t;

    // One-hot phases; HALT is the all-zero encoding.
    typedef enum logic [2:0] {
        ST_HALT  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC1 = 3'b010,
        ST_EXEC2 = 3'b100
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MUL0 = 4'b0010;
    localparam logic [3:0] OP_MUL1 = 4'b0011;
    localparam logic [3:0] OP_B    = 4'b0100;
    localparam logic [3:0] OP_BZ   = 4'b0101;
    localparam logic [3:0] OP_HLT  = 4'b0111;
    localparam logic [3:0] OP_LDR  = 4'b1110;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LDR,
        CLS_MUL,
        CLS_B,
        CLS_BZ,
        CLS_HLT
    } op_class_t;

    // LDR sits inside the 1xxx ALU space, so it must be tested first.
    // Unassigned 0xxx opcodes fall through to NOP.
    function automatic op_class_t decode_op(input logic [3:0] op);
        op_class_t cls;
        cls = CLS_NOP;
        if (op == OP_LDR) begin
            cls = CLS_LDR;
        end else if (op[3]) begin
            cls = CLS_ALU;
        end else begin
            case (op)
                OP_MUL0, OP_MUL1: cls = CLS_MUL;
                OP_B:             cls = CLS_B;
                OP_BZ:            cls = CLS_BZ;
                OP_HLT:           cls = CLS_HLT;
                default:          cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/arm_seq_if.sv
// -----------------------------------------------------------------------------
// arm_seq_if
// Bundles everything the sequencer exchanges with the instruction memory,
// ALU, multiplier and run control.
//   imem_addr  : instruction address (= PC)        seq -> mem
//   imem_data  : instruction word, same cycle       mem -> seq
//   inst       : instruction register              seq -> ALU
//   state      : one-hot phase                     seq -> datapath
//   alu_zero   : ALU result is zero                ALU -> seq
//   mult_start : one-cycle multiplier start        seq -> mult
//   mult_done  : multiplier result valid (level)   mult -> seq
//   mul_wen    : register write for MUL result     seq -> regfile
//   run        : restart from HALT                 ctrl -> seq
//   halted     : sequencer is in HALT              seq -> ctrl
// Modports: master = sequencer side, slave = surrounding datapath side.
// -----------------------------------------------------------------------------
interface arm_seq_if;
    import arm_pkg::*;

    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [15:0]     inst;
    logic [2:0]      state;
    logic            alu_zero;
    logic            mult_start;
    logic            mult_done;
    logic            mul_wen;
    logic            run;
    logic            halted;

    modport master (
        output imem_addr, inst, state, mult_start, mul_wen, halted,
        input  imem_data, alu_zero, mult_done, run
    );

    modport slave (
        input  imem_addr, inst, state, mult_start, mul_wen, halted,
        output imem_data, alu_zero, mult_done, run
    );

endinterface

// File: rtl/arm_seq.sv
// -----------------------------------------------------------------------------
// arm_seq
// Instruction sequencer: FETCH -> EXEC1 (-> EXEC2 for LDR) -> FETCH, with a
// multiplier stall in EXEC1 and a HALT phase left only by run.
// Holds PC, instruction register and the Z flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : arm_seq_if.master (memory, ALU, multiplier and run control)
// All outputs are registered except mult_start and mul_wen, which are decoded
// from the current phase, instruction and mult_done.
// -----------------------------------------------------------------------------
module arm_seq
    import arm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    arm_seq_if.master    bus
);

    state_t      state_q, state_d;
    pc_t         pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        z_q, z_d;
    logic        halted_q, halted_d;
    logic        mul_busy_q, mul_busy_d;
    logic        mult_start_c;
    logic        mul_wen_c;
    op_class_t   op_cls;

    assign op_cls = decode_op(ir_q[15:12]);

    // Next-state and decoded strobes. mul_busy marks that the multiplier has
    // already been started for the current MUL, so mult_start is only high
    // on the first EXEC1 cycle. A done in that same first cycle completes the
    // MUL immediately with both strobes high. An illegal phase value falls
    // into the default arm and recovers to FETCH.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        z_d          = z_q;
        mul_busy_d   = mul_busy_q;
        mult_start_c = 1'b0;
        mul_wen_c    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + pc_t'(1);
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                state_d = ST_FETCH;
                case (op_cls)
                    CLS_ALU: z_d = bus.alu_zero;
                    CLS_LDR: state_d = ST_EXEC2;
                    CLS_MUL: begin
                        mult_start_c = !mul_busy_q;
                        if (bus.mult_done) begin
                            mul_wen_c  = 1'b1;
                            mul_busy_d = 1'b0;
                        end else begin
                            mul_busy_d = 1'b1;
                            state_d    = ST_EXEC1;
                        end
                    end
                    CLS_B:   pc_d = ir_q[PC_W-1:0];
                    CLS_BZ: begin
                        if (z_q) begin
                            pc_d = ir_q[PC_W-1:0];
                        end
                    end
                    CLS_HLT: state_d = ST_HALT;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_EXEC2: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = bus.run ? ST_FETCH : ST_HALT;
            end
            default: begin
                state_d    = ST_FETCH;
                mul_busy_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // Architectural registers; reset wins over everything, including a MUL
    // stall, so the multiplier-busy marker is cleared with the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            z_q        <= 1'b0;
            halted_q   <= 1'b0;
            mul_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            z_q        <= z_d;
            halted_q   <= halted_d;
            mul_busy_q <= mul_busy_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.inst       = ir_q;
    assign bus.state      = state_q;
    assign bus.halted     = halted_q;
    assign bus.mult_start = mult_start_c;
    assign bus.mul_wen    = mul_wen_c;

endmodule
